// File: rtl/vrf_read_sequencer.sv
// Purpose: walks one read instruction's {groupIndex, offset} slices into VRF read requests and returns the data in order.
// Latency: inst fire to first req_valid 1 cycle; data fire to out_valid 1 cycle (registered result).
// Backpressure: req_valid is metered by a credit counter; data_ready drops while the result register is full and not draining.
//
// Ports:
//   clock, reset          - clock; synchronous active-high reset
//   inst_*                - instruction offer (accepted only in IDLE)
//   req_*                 - read requests to the read pipe enqueue side
//   data_*                - read data from the read pipe dequeue side
//   out_*                 - registered result stream {bits, index, last}
//   busy                  - an instruction is in flight
module vrf_read_sequencer #(
    parameter int CREDITS    = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inst_valid,
    output logic                  inst_ready,
    input  logic [4:0]            inst_vs,
    input  logic [5:0]            inst_count,
    input  logic [3:0]            inst_readSource,
    input  logic [2:0]            inst_instructionIndex,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [4:0]            req_vs,
    output logic [1:0]            req_offset,
    output logic [3:0]            req_groupIndex,
    output logic [3:0]            req_readSource,
    output logic [2:0]            req_instructionIndex,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic [DATA_WIDTH-1:0] data_bits,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_bits,
    output logic [5:0]            out_index,
    output logic                  out_last,
    output logic                  busy
);

    localparam int CW = $clog2(CREDITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    state_t        stateNext;
    logic [4:0]    vsQ;
    logic [5:0]    countQ;
    logic [3:0]    readSourceQ;
    logic [2:0]    instructionIndexQ;
    logic [5:0]    idx;
    logic [5:0]    rx;
    logic [CW-1:0] cred;

    logic instFire;
    logic reqFire;
    logic dataFire;
    logic outFire;

    assign inst_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign req_valid  = (state == ISSUE) && (cred < CW'(CREDITS));

    // The read pipe stalls its enqueue side while dequeue is blocked, so
    // data_ready must never wait on request activity or the two would deadlock.
    assign data_ready = (state != IDLE) && (cred != '0) && (!out_valid || out_ready);

    assign instFire = inst_valid && inst_ready;
    assign reqFire  = req_valid && req_ready;
    assign dataFire = data_valid && data_ready;
    assign outFire  = out_valid && out_ready;

    assign req_vs               = vsQ;
    assign req_offset           = idx[1:0];
    assign req_groupIndex       = idx[5:2];
    assign req_readSource       = readSourceQ;
    assign req_instructionIndex = instructionIndexQ;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (instFire) stateNext = ISSUE;
            ISSUE:   if (reqFire && (idx == countQ)) stateNext = DRAIN;
            DRAIN:   if (outFire && out_last) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            vsQ               <= '0;
            countQ            <= '0;
            readSourceQ       <= '0;
            instructionIndexQ <= '0;
            idx               <= '0;
            rx                <= '0;
            cred              <= '0;
            out_valid         <= 1'b0;
            out_bits          <= '0;
            out_index         <= '0;
            out_last          <= 1'b0;
        end else begin
            state <= stateNext;

            if (instFire) begin
                vsQ               <= inst_vs;
                countQ            <= inst_count;
                readSourceQ       <= inst_readSource;
                instructionIndexQ <= inst_instructionIndex;
                idx               <= '0;
                rx                <= '0;
            end else begin
                // idx parks on count after the final request
                if (reqFire && (idx != countQ)) idx <= idx + 6'd1;
                if (dataFire) rx <= rx + 6'd1;
            end

            // A request and a returning beat in the same cycle cancel out.
            case ({reqFire, dataFire})
                2'b10:   cred <= cred + CW'(1);
                2'b01:   cred <= cred - CW'(1);
                default: cred <= cred;
            endcase

            if (dataFire) begin
                out_valid <= 1'b1;
                out_bits  <= data_bits;
                out_index <= rx;
                out_last  <= (rx == countQ);
            end else if (outFire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vrf_read_sequencer.sv
module tb_vrf_read_sequencer;

    localparam int CREDITS = 4;
    localparam int DW      = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          inst_valid = 1'b0;
    logic          inst_ready;
    logic [4:0]    inst_vs = '0;
    logic [5:0]    inst_count = '0;
    logic [3:0]    inst_readSource = '0;
    logic [2:0]    inst_instructionIndex = '0;
    logic          req_valid;
    logic          req_ready = 1'b0;
    logic [4:0]    req_vs;
    logic [1:0]    req_offset;
    logic [3:0]    req_groupIndex;
    logic [3:0]    req_readSource;
    logic [2:0]    req_instructionIndex;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic [DW-1:0] data_bits = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_bits;
    logic [5:0]    out_index;
    logic          out_last;
    logic          busy;

    vrf_read_sequencer #(.CREDITS(CREDITS), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_vs(inst_vs), .inst_count(inst_count),
        .inst_readSource(inst_readSource), .inst_instructionIndex(inst_instructionIndex),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_vs(req_vs), .req_offset(req_offset), .req_groupIndex(req_groupIndex),
        .req_readSource(req_readSource), .req_instructionIndex(req_instructionIndex),
        .data_valid(data_valid), .data_ready(data_ready), .data_bits(data_bits),
        .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
        .out_index(out_index), .out_last(out_last), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] dat;
        int          rdy;
    } pipe_t;

    typedef struct {
        logic [31:0] dat;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    typedef struct {
        logic [4:0] vs;
        logic [5:0] count;
        logic [3:0] rs;
        logic [2:0] ii;
        int         lat;
        int         reqPct;
        int         outPct;
        int         expOuts;
        int         expLastIdx;
        int         maxCyc;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // stimulus knobs
    int reqPct = 100;
    int outPct = 100;
    int lat    = 2;
    bit holdData = 1'b0;
    bit rstReq = 1'b1;
    bit instPending = 1'b0;
    logic [4:0] pVs;
    logic [5:0] pCount;
    logic [3:0] pRs;
    logic [2:0] pIi;
    logic [7:0] pSalt;

    // reference model
    pipe_t pipeQ[$];
    exp_t  expQ[$];
    bit    mBusy = 0;
    bit    mIssuing = 0;
    bit    mOutValid = 0;
    int    outstanding = 0;
    logic [4:0] mVs;
    logic [5:0] mCount;
    logic [3:0] mRs;
    logic [2:0] mIi;
    logic [7:0] mSalt;
    logic [5:0] mIdx;
    int    nReq = 0;
    int    nOut = 0;
    int    lastIdx = -1;
    int    simFires = 0;

    function automatic logic [31:0] mkWord(logic [7:0] salt, logic [2:0] ii, logic [3:0] rs,
                                           logic [4:0] vs, logic [3:0] gi, logic [1:0] off);
        return {salt, 3'b000, ii, rs, vs, 3'b101, gi, off};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clearModel();
        pipeQ.delete();
        expQ.delete();
        mBusy = 0;
        mIssuing = 0;
        mOutValid = 0;
        outstanding = 0;
        instPending = 0;
    endtask

    // One clock: drive inputs after the falling edge, then sample and advance the model.
    task automatic step();
        bit instF, rf, df, ofire;
        exp_t e;
        @(negedge clock);
        cyc++;
        reset                 = rstReq;
        req_ready             = ($urandom_range(99) < reqPct);
        out_ready             = ($urandom_range(99) < outPct);
        inst_valid            = instPending;
        inst_vs               = pVs;
        inst_count            = pCount;
        inst_readSource       = pRs;
        inst_instructionIndex = pIi;
        if (!holdData && pipeQ.size() > 0 && pipeQ[0].rdy <= cyc) begin
            data_valid = 1'b1;
            data_bits  = pipeQ[0].dat;
        end else begin
            data_valid = 1'b0;
            data_bits  = $urandom;
        end
        #1;
        if (reset) begin
            clearModel();
            return;
        end
        chk("inst_ready", inst_ready, !mBusy);
        chk("busy", busy, mBusy);
        chk("req_valid", req_valid, mIssuing && (outstanding < CREDITS));
        chk("data_ready", data_ready, mBusy && (outstanding != 0) && (!mOutValid || out_ready));
        chk("out_valid", out_valid, mOutValid);

        instF = inst_valid && inst_ready;
        rf    = req_valid && req_ready;
        df    = data_valid && data_ready;
        ofire = out_valid && out_ready;
        if (rf && df) simFires++;

        if (ofire) begin
            if (expQ.size() == 0) begin
                chk("out_unexpected", 1, 0);
            end else begin
                e = expQ.pop_front();
                chk("out_bits", out_bits, e.dat);
                chk("out_index", out_index, e.idx);
                chk("out_last", out_last, e.last);
                nOut++;
                if (out_last) begin
                    lastIdx = out_index;
                    mBusy = 0;
                end
            end
        end
        if (df) begin
            void'(pipeQ.pop_front());
            outstanding--;
        end
        mOutValid = df ? 1'b1 : (ofire ? 1'b0 : mOutValid);
        if (rf && mIssuing) begin
            chk("req_vs", req_vs, mVs);
            chk("req_groupIndex", req_groupIndex, mIdx[5:2]);
            chk("req_offset", req_offset, mIdx[1:0]);
            chk("req_readSource", req_readSource, mRs);
            chk("req_instructionIndex", req_instructionIndex, mIi);
            pipeQ.push_back('{mkWord(mSalt, req_instructionIndex, req_readSource, req_vs,
                                     req_groupIndex, req_offset), cyc + lat});
            expQ.push_back('{mkWord(mSalt, mIi, mRs, mVs, mIdx[5:2], mIdx[1:0]), mIdx, mIdx == mCount});
            outstanding++;
            nReq++;
            if (mIdx == mCount) mIssuing = 0;
            else mIdx = mIdx + 6'd1;
        end
        if (instF) begin
            instPending = 0;
            mVs = pVs; mCount = pCount; mRs = pRs; mIi = pIi; mSalt = pSalt;
            mIdx = '0;
            mIssuing = 1;
            mBusy = 1;
        end
    endtask

    task automatic startInst(input logic [4:0] vs, input logic [5:0] count,
                             input logic [3:0] rs, input logic [2:0] ii);
        pVs = vs; pCount = count; pRs = rs; pIi = ii;
        pSalt = 8'($urandom);
        instPending = 1;
        nReq = 0;
        nOut = 0;
        lastIdx = -1;
    endtask

    task automatic waitDone(input string nm, input int bound, output int used);
        int n = 0;
        while ((instPending || mBusy) && n < bound) begin
            step();
            n++;
        end
        used = n;
        if (instPending || mBusy) chk({nm, "_timeout"}, 1, 0);
    endtask

    vec_t vecs[6];

    initial begin
        int used;
        logic [DW-1:0] held;

        vecs[0] = '{5'd5,  6'd0,  4'd2, 3'd3, 2, 100, 100, 1,  0,  0};
        vecs[1] = '{5'd17, 6'd63, 4'd9, 3'd6, 2, 100, 100, 64, 63, 75};
        vecs[2] = '{5'd31, 6'd17, 4'd1, 3'd0, 1, 70,  60,  18, 17, 0};
        vecs[3] = '{5'd0,  6'd3,  4'd15,3'd7, 4, 50,  30,  4,  3,  0};
        vecs[4] = '{5'd12, 6'd31, 4'd6, 3'd2, 3, 90,  90,  32, 31, 0};
        vecs[5] = '{5'd9,  6'd1,  4'd4, 3'd5, 1, 100, 100, 2,  1,  0};

        // reset state
        rstReq = 1;
        step();
        step();
        rstReq = 0;
        step();
        chk("rst_out_bits", out_bits, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_last", out_last, 0);

        // table-driven instructions
        for (int i = 0; i < 6; i++) begin
            reqPct = vecs[i].reqPct;
            outPct = vecs[i].outPct;
            lat    = vecs[i].lat;
            simFires = 0;
            startInst(vecs[i].vs, vecs[i].count, vecs[i].rs, vecs[i].ii);
            waitDone("vec", 3000, used);
            chk("vec_nOut", nOut, vecs[i].expOuts);
            chk("vec_nReq", nReq, vecs[i].expOuts);
            chk("vec_lastIdx", lastIdx, vecs[i].expLastIdx);
            if (vecs[i].maxCyc != 0) begin
                chk("vec_throughput", used <= vecs[i].maxCyc, 1);
                chk("vec_simfire_seen", simFires != 0, 1);
            end
            step();
            chk("vec_idle_inst_ready", inst_ready, 1);
        end

        // credit stall: data withheld, then one beat released
        reqPct = 100; outPct = 100; lat = 1; holdData = 1;
        startInst(5'd3, 6'd9, 4'd8, 3'd1);
        repeat (10) step();
        chk("stall_reqs", nReq, CREDITS);
        chk("stall_req_valid", req_valid, 0);
        holdData = 0;
        step();
        holdData = 1;
        repeat (5) step();
        chk("stall_release_reqs", nReq, CREDITS + 1);
        chk("stall_release_out", nOut, 1);
        holdData = 0;
        waitDone("stall", 500, used);
        chk("stall_nOut", nOut, 10);

        // result backpressure: output register fills, everything behind it waits
        outPct = 0;
        startInst(5'd20, 6'd7, 4'd3, 3'd4);
        repeat (15) step();
        chk("bp_reqs", nReq, CREDITS + 1);
        chk("bp_data_ready", data_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        held = out_bits;
        repeat (6) step();
        chk("bp_out_bits_held", out_bits, held);
        chk("bp_reqs_held", nReq, CREDITS + 1);
        outPct = 100;
        waitDone("bp", 500, used);
        chk("bp_nOut", nOut, 8);

        // reset while issuing with three credits outstanding
        holdData = 1;
        startInst(5'd7, 6'd20, 4'd5, 3'd2);
        step();
        repeat (3) step();
        chk("rstmid_reqs", nReq, 3);
        rstReq = 1;
        step();
        rstReq = 0;
        holdData = 0;
        step();
        chk("rstmid_busy", busy, 0);
        chk("rstmid_req_valid", req_valid, 0);
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_data_ready", data_ready, 0);
        startInst(5'd11, 6'd5, 4'd12, 3'd3);
        waitDone("rstmid", 500, used);
        chk("rstmid_nOut", nOut, 6);
        chk("rstmid_lastIdx", lastIdx, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
